// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: packet-locked round-robin merge of N valid/ready streams
// onto one registered output with a two-entry skid stage.
module stream_rr_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         s_valid,
    input  logic [N-1:0]         s_last,
    input  logic [N*WIDTH-1:0]   s_data,
    output logic [N-1:0]         s_ready,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_last,
    output logic [ID_W-1:0]      m_id,
    output logic                 busy
);
    localparam logic IDLE   = 1'b0;
    localparam logic LOCKED = 1'b1;

    logic             state, skid_full, skid_last, found, hs, in_last;
    logic [ID_W-1:0]  ptr, grant, pick, skid_id;
    logic [WIDTH-1:0] skid_data, in_data;
    int               j;

    // first requester at or after ptr, wrapping
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && s_valid[j]) begin
                pick  = ID_W'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++)
            s_ready[i] = (state == LOCKED) && !skid_full && (grant == ID_W'(i));
    end

    assign hs      = (state == LOCKED) && !skid_full && s_valid[grant];
    assign in_data = s_data[int'(grant)*WIDTH +: WIDTH];
    assign in_last = s_last[grant];
    assign busy    = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            m_valid   <= 1'b0;
            skid_full <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (found) begin
                    grant <= pick;
                    state <= LOCKED;
                end
            end else if (hs && in_last) begin
                state <= IDLE;
                ptr   <= (grant == ID_W'(N-1)) ? '0 : grant + 1'b1;
            end
            // a full skid blocks hs, so draining skid never races a new beat
            if (m_valid && m_ready) begin
                if (skid_full) begin
                    m_data    <= skid_data;
                    m_last    <= skid_last;
                    m_id      <= skid_id;
                    skid_full <= 1'b0;
                end else begin
                    m_valid <= hs;
                    if (hs) begin
                        m_data <= in_data;
                        m_last <= in_last;
                        m_id   <= grant;
                    end
                end
            end else if (hs) begin
                if (!m_valid) begin
                    m_valid <= 1'b1;
                    m_data  <= in_data;
                    m_last  <= in_last;
                    m_id    <= grant;
                end else begin
                    skid_full <= 1'b1;
                    skid_data <= in_data;
                    skid_last <= in_last;
                    skid_id   <= grant;
                end
            end
        end
    end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: random traffic against a queue-based model of the arbiter
module tb_stream_rr_arbiter;
    localparam int N = 4, W = 8, IW = 2;

    logic            clk = 1'b0, rst;
    logic [N-1:0]    s_valid, s_last, s_ready;
    logic [N*W-1:0]  s_data;
    logic            m_valid, m_ready, m_last, busy;
    logic [W-1:0]    m_data;
    logic [IW-1:0]   m_id;

    typedef struct { int d; int l; int id; } beat_t;
    beat_t q[$];
    int owner, ptr, checks = 0, errs = 0;

    always #5 clk = ~clk;

    stream_rr_arbiter #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_last(s_last), .s_data(s_data),
        .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .m_id(m_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    initial begin
        rst = 1'b1; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        owner = -1; ptr = 0; q.delete();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit hs, pop, found;
            @(negedge clk);
            // the model state here mirrors what the DUT registers after the last edge
            chk("s_ready", 32'(s_ready), (owner >= 0 && q.size() < 2) ? (32'd1 << owner) : 32'd0);
            chk("m_valid", 32'(m_valid), 32'(q.size() > 0));
            chk("busy", 32'(busy), 32'(owner >= 0));
            if (q.size() > 0) begin
                chk("m_data", 32'(m_data), q[0].d);
                chk("m_last", 32'(m_last), q[0].l);
                chk("m_id", 32'(m_id), q[0].id);
            end
            rst = (cyc >= 2500) && ($urandom_range(0, 49) == 0);
            for (int i = 0; i < N; i++) begin
                s_valid[i] = (cyc >= 10) && ($urandom_range(0, 9) < 7);
                s_last[i]  = $urandom_range(0, 9) < 3;
            end
            s_data  = $urandom;
            m_ready = (cyc < 1500) ? ($urandom_range(0, 9) < 7) :
                      (cyc < 2500) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6);
            if (rst) begin
                q.delete(); owner = -1; ptr = 0;
            end else begin
                hs  = owner >= 0 && q.size() < 2 && s_valid[owner];
                pop = q.size() > 0 && m_ready;
                if (pop) void'(q.pop_front());
                if (hs) q.push_back('{int'(s_data[owner*W +: W]), int'(s_last[owner]), owner});
                if (hs && s_last[owner]) begin
                    ptr = (owner + 1) % N;
                    owner = -1;
                end else if (owner < 0) begin
                    found = 1'b0;
                    for (int k = 0; k < N; k++)
                        if (!found && s_valid[(ptr + k) % N]) begin
                            owner = (ptr + k) % N;
                            found = 1'b1;
                        end
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end
endmodule
